game_screen_ctrl: RTL and testbench

Frame-synchronous mode controller for the VGA game screen. Sequences title, play, pause and game-over modes from the start button and the game's death signal, and selects which 8-bit sprite colour stream reaches the VGA RGB pins. Sits between the sprite ROM blocks (title, game field, game-over overlay) and the VGA output, driven by the same `hc`/`vc` counters.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/btn_sync_edge.sv | 33 +++
 rtl/game_screen_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_screen_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared VGA timing defaults, screen mode encodings and colour helpers.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_TITLE  = 2'd0,
        MODE_PLAY   = 2'd1,
        MODE_PAUSED = 2'd2,
        MODE_OVER   = 2'd3
    } mode_t;

    localparam int DEF_HBP = 144;
    localparam int DEF_HFP = 784;
    localparam int DEF_VBP = 31;
    localparam int DEF_VFP = 511;

    localparam logic [7:0] TRANSPARENT = 8'hFF;

    // Halve each channel of a packed {R3,G3,B2} colour.
    function automatic logic [7:0] dim_rgb(input logic [7:0] c);
        return {1'b0, c[7:6], 1'b0, c[4:3], 1'b0, c[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_sync_edge                                                        |
// | Two-flop synchroniser for a raw button plus rising-edge pulse.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic sync0;
    logic sync1;
    logic sync1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync1_d <= 1'b0;
        end else begin
            sync0   <= raw;
            sync1   <= sync0;
            sync1_d <= sync1;
        end
    end

    assign rise = sync1 & ~sync1_d;

endmodule
`default_nettype wire

// File: rtl/game_screen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_screen_ctrl                                                     |
// | Frame-synchronous title/play/pause/over sequencer and RGB selector.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module game_screen_ctrl
    import vga_pkg::*;
#(
    parameter int         HBP          = DEF_HBP,
    parameter int         HFP          = DEF_HFP,
    parameter int         VBP          = DEF_VBP,
    parameter int         VFP          = DEF_VFP,
    parameter int         BLINK_FRAMES = 30,
    parameter int         OVER_FRAMES  = 180,
    parameter logic [7:0] BG_COLOR     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic        start_btn,
    input  logic        player_dead,
    input  logic [7:0]  title_rgb,
    input  logic [7:0]  game_rgb,
    input  logic [7:0]  over_rgb,
    output logic [2:0]  R,
    output logic [2:0]  G,
    output logic [1:0]  B,
    output logic [1:0]  mode,
    output logic        game_en,
    output logic        game_rst
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int OW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_FRAMES - 1);
    localparam logic [10:0]   HBP_C = 11'(HBP);
    localparam logic [10:0]   HFP_C = 11'(HFP);
    localparam logic [10:0]   VBP_C = 11'(VBP);
    localparam logic [10:0]   VFP_C = 11'(VFP);

    mode_t         state;
    mode_t         state_nxt;
    logic          start_rise;
    logic          tick;
    logic          start_pend;
    logic          dead_pend;
    logic [OW-1:0] over_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic          active;
    logic [7:0]    pix;

    btn_sync_edge u_start_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (start_btn),
        .rise (start_rise)
    );

    assign tick   = (hc == 11'd0) && (vc == 11'd0);
    assign active = (hc >= HBP_C) && (hc < HFP_C) && (vc >= VBP_C) && (vc < VFP_C);
    assign mode   = state;

    // Flags live for one frame; an event on the tick cycle belongs to the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_pend <= 1'b0;
            dead_pend  <= 1'b0;
        end else if (tick) begin
            start_pend <= start_rise;
            dead_pend  <= player_dead;
        end else begin
            start_pend <= start_pend | start_rise;
            dead_pend  <= dead_pend | player_dead;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                MODE_TITLE:  if (start_pend) state_nxt = MODE_PLAY;
                MODE_PLAY: begin
                    if (dead_pend)       state_nxt = MODE_OVER;
                    else if (start_pend) state_nxt = MODE_PAUSED;
                end
                MODE_PAUSED: if (start_pend) state_nxt = MODE_PLAY;
                MODE_OVER:   if (over_cnt == OVER_LAST) state_nxt = MODE_TITLE;
                default:     state_nxt = MODE_TITLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MODE_TITLE;
            game_en  <= 1'b0;
            game_rst <= 1'b0;
        end else begin
            state    <= state_nxt;
            game_en  <= (state_nxt == MODE_PLAY);
            game_rst <= (state == MODE_TITLE) && (state_nxt == MODE_PLAY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            over_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (tick) begin
            if (state == MODE_OVER)
                over_cnt <= (over_cnt == OVER_LAST) ? '0 : over_cnt + OW'(1);
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        pix = 8'h00;
        if (active) begin
            case (state)
                MODE_TITLE:  pix = (blink && (title_rgb != TRANSPARENT)) ? title_rgb : BG_COLOR;
                MODE_PLAY:   pix = game_rgb;
                MODE_PAUSED: pix = dim_rgb(game_rgb);
                MODE_OVER:   pix = (over_rgb != TRANSPARENT) ? over_rgb : game_rgb;
                default:     pix = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) {R, G, B} <= 8'h00;
        else     {R, G, B} <= pix;
    end

endmodule
`default_nettype wire

// File: tb/tb_game_screen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_screen_ctrl                                                  |
// | Directed self-checking bench; hc/vc are driven directly as stimulus. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_game_screen_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        start_btn;
    logic        player_dead;
    logic [7:0]  title_rgb;
    logic [7:0]  game_rgb;
    logic [7:0]  over_rgb;
    logic [2:0]  R;
    logic [2:0]  G;
    logic [1:0]  B;
    logic [1:0]  mode;
    logic        game_en;
    logic        game_rst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_screen_ctrl #(.BG_COLOR(8'h25)) dut (
        .clk         (clk),
        .rst         (rst),
        .hc          (hc),
        .vc          (vc),
        .start_btn   (start_btn),
        .player_dead (player_dead),
        .title_rgb   (title_rgb),
        .game_rgb    (game_rgb),
        .over_rgb    (over_rgb),
        .R           (R),
        .G           (G),
        .B           (B),
        .mode        (mode),
        .game_en     (game_en),
        .game_rst    (game_rst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame-start cycle, then back to an active pixel.
    task automatic tick();
        hc = 11'd0;
        vc = 11'd0;
        cyc(1);
        hc = 11'd300;
        vc = 11'd200;
    endtask

    task automatic press();
        start_btn = 1'b1;
        cyc(5);
        start_btn = 1'b0;
        cyc(5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hc = 11'd300; vc = 11'd200;
        start_btn = 1'b0; player_dead = 1'b0;
        title_rgb = 8'h5A; game_rgb = 8'h1C; over_rgb = 8'hFF;
        cyc(5);
        check("rst_mode", mode, 2'd0);
        check("rst_rgb", {R, G, B}, 8'h00);
        check("rst_game_en", game_en, 1'b0);
        check("rst_game_rst", game_rst, 1'b0);

        rst = 1'b0;
        cyc(1);
        check("title_bg", {R, G, B}, 8'h25);
        repeat (29) tick();
        cyc(1);
        check("blink_off_29", {R, G, B}, 8'h25);
        tick();
        cyc(1);
        check("blink_on_30", {R, G, B}, 8'h5A);
        title_rgb = 8'hFF;
        cyc(1);
        check("title_transp", {R, G, B}, 8'h25);
        title_rgb = 8'h5A;

        press();
        check("start_wait_tick", mode, 2'd0);
        tick();
        check("title_to_play", mode, 2'd1);
        check("game_rst_pulse", game_rst, 1'b1);
        check("play_game_en", game_en, 1'b1);
        cyc(1);
        check("game_rst_one_cycle", game_rst, 1'b0);
        check("play_rgb", {R, G, B}, 8'h1C);

        game_rgb = 8'b111_110_11;
        press();
        tick();
        check("play_to_pause", mode, 2'd2);
        check("pause_game_en", game_en, 1'b0);
        cyc(1);
        check("pause_dim", {R, G, B}, 8'b011_011_01);
        player_dead = 1'b1;
        cyc(3);
        player_dead = 1'b0;
        cyc(2);
        tick();
        check("pause_ignore_dead", mode, 2'd2);
        press();
        tick();
        check("pause_to_play", mode, 2'd1);
        check("resume_game_en", game_en, 1'b1);
        cyc(1);
        check("resume_rgb", {R, G, B}, 8'hFB);

        game_rgb = 8'h1C;
        start_btn = 1'b1; player_dead = 1'b1;
        cyc(5);
        start_btn = 1'b0; player_dead = 1'b0;
        cyc(5);
        tick();
        check("death_wins", mode, 2'd3);
        check("over_game_en", game_en, 1'b0);
        cyc(1);
        check("over_transp", {R, G, B}, 8'h1C);
        over_rgb = 8'hE0;
        cyc(1);
        check("over_overlay", {R, G, B}, 8'hE0);
        hc = 11'd100;
        cyc(1);
        check("over_blank", {R, G, B}, 8'h00);
        hc = 11'd300;

        for (int i = 1; i < 180; i++) begin
            if (i % 45 == 0) press();
            tick();
        end
        check("over_hold_179", mode, 2'd3);
        press();
        tick();
        check("over_exit_180", mode, 2'd0);
        tick();
        check("over_start_dropped", mode, 2'd0);

        start_btn = 1'b1;
        cyc(2);
        hc = 11'd0; vc = 11'd0;
        cyc(1);
        hc = 11'd300; vc = 11'd200;
        check("edge_on_tick", mode, 2'd0);
        start_btn = 1'b0;
        cyc(4);
        check("edge_on_tick_hold", mode, 2'd0);
        tick();
        check("edge_next_tick", mode, 2'd1);
        check("edge_game_rst", game_rst, 1'b1);

        press();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_mode", mode, 2'd0);
        check("midrst_game_en", game_en, 1'b0);
        check("midrst_rgb", {R, G, B}, 8'h00);
        tick();
        check("midrst_pend_cleared", mode, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
